// File: rtl/siso_pkg.sv
// Shared types, constants and helper functions for the SISO decoder state-metric units.
// Metrics are W-bit two's complement; intermediate sums carry two guard bits.
package siso_pkg;

   localparam int W           = 16;
   localparam int NSTATES     = 8;
   localparam int MAX_LEN     = 6144;
   localparam int INIT_METRIC = -128;

   typedef enum logic {FILL, RECUR} state_e;

   typedef logic signed [W-1:0] metric_t;
   typedef logic signed [W+1:0] wide_t;

   function automatic wide_t max2(input wide_t a, input wide_t b);
      return (a > b) ? a : b;
   endfunction

   // The value fits in W bits only when the top three bits agree.
   function automatic metric_t sat_w(input wide_t x);
      metric_t r;
      if ((x[W+1:W-1] == 3'b000) || (x[W+1:W-1] == 3'b111)) begin
         r = metric_t'(x[W-1:0]);
      end else if (x[W+1]) begin
         r = metric_t'({1'b1, {(W-1){1'b0}}});
      end else begin
         r = metric_t'({1'b0, {(W-1){1'b1}}});
      end
      return r;
   endfunction

endpackage

// File: rtl/branch_lifo.sv
// Single-port branch-metric store with a registered, enable-gated read port.
// Writes and reads are mutually exclusive; en with !we performs a read.
module branch_lifo
   import siso_pkg::*;
#(
   parameter int DEPTH = siso_pkg::MAX_LEN,
   parameter int DW    = 2 * siso_pkg::W,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   // Read data holds while en is low, which freezes the read stage on backpressure.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/beta_recursion.sv
// Backward state-metric recursion: buffers a block of branch metrics, then replays them
// in reverse through the 8-state trellis, emitting normalized betas with the echoed gammas.
module beta_recursion
   import siso_pkg::*;
#(
   parameter int MAX_LEN = siso_pkg::MAX_LEN,
   localparam int AW     = $clog2(MAX_LEN),
   localparam int CW     = AW + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          fsm_state,
   input  logic                valid_branch,
   input  logic                last_branch,
   input  logic signed [W-1:0] init_branch1,
   input  logic signed [W-1:0] init_branch2,
   output logic                ready_in,
   output logic signed [W-1:0] beta_0,
   output logic signed [W-1:0] beta_1,
   output logic signed [W-1:0] beta_2,
   output logic signed [W-1:0] beta_3,
   output logic signed [W-1:0] beta_4,
   output logic signed [W-1:0] beta_5,
   output logic signed [W-1:0] beta_6,
   output logic signed [W-1:0] beta_7,
   output logic signed [W-1:0] branch1_out,
   output logic signed [W-1:0] branch2_out,
   output logic [AW-1:0]       beta_idx,
   output logic                valid_beta,
   output logic                last_beta,
   input  logic                out_ready,
   output logic                err_overflow
);

   state_e        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          err_q, err_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic          rd_pend_q, rd_pend_d;
   logic          rd_valid_q, rd_valid_d;
   logic [AW-1:0] rd_idx_q, rd_idx_d;
   logic          first_q, first_d;
   metric_t       beta_q [NSTATES];
   metric_t       beta_d [NSTATES];
   metric_t       br1_q, br1_d, br2_q, br2_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          valid_q, valid_d;
   logic          last_q, last_d;

   logic          wr_en, rd_en;
   logic [AW-1:0] lifo_addr;
   logic [2*W-1:0] rd_data;
   logic          out_xfer, out_load;
   metric_t       beta_next [NSTATES];

   assign out_xfer  = valid_q && out_ready;
   assign out_load  = rd_valid_q && (!valid_q || out_ready);
   assign lifo_addr = (state_q == FILL) ? count_q[AW-1:0] : rd_addr_q;

   branch_lifo #(
      .DEPTH (MAX_LEN),
      .DW    (2 * W)
   ) u_lifo (
      .clk   (clk),
      .en    (wr_en || rd_en),
      .we    (wr_en),
      .addr  (lifo_addr),
      .wdata ({init_branch1, init_branch2}),
      .rdata (rd_data)
   );

   // The next beta comes from the currently presented beta and the gamma echoed with it.
   always_comb begin
      wide_t b [NSTATES];
      wide_t nb [NSTATES];
      wide_t g1, g2;
      for (int i = 0; i < NSTATES; i++) begin
         b[i] = wide_t'(beta_q[i]);
      end
      g1 = wide_t'(br1_q);
      g2 = wide_t'(br2_q);
      nb[0] = max2(b[0] + g1, b[4] - g1);
      nb[1] = max2(b[0] - g1, b[4] + g1);
      nb[2] = max2(b[1] - g2, b[5] + g2);
      nb[3] = max2(b[1] + g2, b[5] - g2);
      nb[4] = max2(b[2] + g2, b[6] - g2);
      nb[5] = max2(b[2] - g2, b[6] + g2);
      nb[6] = max2(b[3] - g1, b[7] + g1);
      nb[7] = max2(b[3] + g1, b[7] - g1);
      for (int i = 0; i < NSTATES; i++) begin
         beta_next[i] = sat_w(nb[i] - nb[0]);
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      err_d      = err_q;
      rd_addr_d  = rd_addr_q;
      rd_pend_d  = rd_pend_q;
      rd_valid_d = rd_valid_q;
      rd_idx_d   = rd_idx_q;
      first_d    = first_q;
      beta_d     = beta_q;
      br1_d      = br1_q;
      br2_d      = br2_q;
      idx_d      = idx_q;
      valid_d    = valid_q;
      last_d     = last_q;
      wr_en      = 1'b0;
      rd_en      = 1'b0;

      case (state_q)
         FILL: begin
            if (valid_branch) begin
               if (count_q < CW'(MAX_LEN)) begin
                  wr_en   = 1'b1;
                  count_d = count_q + CW'(1);
               end else begin
                  err_d = 1'b1;
               end
               if (last_branch) begin
                  state_d   = RECUR;
                  rd_pend_d = 1'b1;
                  first_d   = 1'b1;
                  rd_addr_d = (count_q < CW'(MAX_LEN)) ? count_q[AW-1:0] : AW'(MAX_LEN - 1);
               end
            end
         end
         RECUR: begin
            // A new read is issued only when the read register is empty or draining.
            rd_en = rd_pend_q && (!rd_valid_q || out_load);
            if (rd_en) begin
               rd_valid_d = 1'b1;
               rd_idx_d   = rd_addr_q;
               if (rd_addr_q == '0) begin
                  rd_pend_d = 1'b0;
               end else begin
                  rd_addr_d = rd_addr_q - AW'(1);
               end
            end else if (out_load) begin
               rd_valid_d = 1'b0;
            end

            if (out_load) begin
               for (int i = 0; i < NSTATES; i++) begin
                  beta_d[i] = first_q ? ((i == 0) ? '0 : metric_t'(INIT_METRIC)) : beta_next[i];
               end
               br1_d   = metric_t'(rd_data[2*W-1:W]);
               br2_d   = metric_t'(rd_data[W-1:0]);
               idx_d   = rd_idx_q;
               last_d  = (rd_idx_q == '0);
               valid_d = 1'b1;
               first_d = 1'b0;
            end else if (out_xfer) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
            end

            if (out_xfer && last_q) begin
               state_d = FILL;
               count_d = '0;
            end
         end
         default: state_d = FILL;
      endcase

      // Decoder phase 00 is a synchronous clear that wins over everything above.
      if (fsm_state == 2'b00) begin
         state_d    = FILL;
         count_d    = '0;
         err_d      = 1'b0;
         rd_pend_d  = 1'b0;
         rd_valid_d = 1'b0;
         first_d    = 1'b0;
         for (int i = 0; i < NSTATES; i++) begin
            beta_d[i] = '0;
         end
         br1_d   = '0;
         br2_d   = '0;
         idx_d   = '0;
         valid_d = 1'b0;
         last_d  = 1'b0;
         wr_en   = 1'b0;
         rd_en   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= FILL;
         count_q    <= '0;
         err_q      <= 1'b0;
         rd_addr_q  <= '0;
         rd_pend_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_idx_q   <= '0;
         first_q    <= 1'b0;
         for (int i = 0; i < NSTATES; i++) begin
            beta_q[i] <= '0;
         end
         br1_q   <= '0;
         br2_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         err_q      <= err_d;
         rd_addr_q  <= rd_addr_d;
         rd_pend_q  <= rd_pend_d;
         rd_valid_q <= rd_valid_d;
         rd_idx_q   <= rd_idx_d;
         first_q    <= first_d;
         for (int i = 0; i < NSTATES; i++) begin
            beta_q[i] <= beta_d[i];
         end
         br1_q   <= br1_d;
         br2_q   <= br2_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign ready_in     = (state_q == FILL);
   assign beta_0       = beta_q[0];
   assign beta_1       = beta_q[1];
   assign beta_2       = beta_q[2];
   assign beta_3       = beta_q[3];
   assign beta_4       = beta_q[4];
   assign beta_5       = beta_q[5];
   assign beta_6       = beta_q[6];
   assign beta_7       = beta_q[7];
   assign branch1_out  = br1_q;
   assign branch2_out  = br2_q;
   assign beta_idx     = idx_q;
   assign valid_beta   = valid_q;
   assign last_beta    = last_q;
   assign err_overflow = err_q;

endmodule
